// File: rtl/pe_psum_drain.sv
// PPad drain reader: reads PPad entries 0..N-1 in order and streams them out
// through a 2-entry output FIFO on a valid/ready port, pulsing done at the end.
module pe_psum_drain #(
  parameter int unsigned PsumDWd    = 16,
  parameter int unsigned PPadSize   = 64,
  parameter int unsigned PPadAddrWd = $clog2(PPadSize)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  drain_start_i,
  input  logic [6:0]            ppad_size_i,
  output logic                  ppad_read_o,
  output logic [PPadAddrWd-1:0] ppad_raddr_o,
  input  logic [PsumDWd-1:0]    ppad_rdata_i,
  output logic                  psum_valid_o,
  input  logic                  psum_ready_i,
  output logic [PsumDWd-1:0]    psum_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned SizeWd = 7;
  localparam int unsigned OccWd  = 3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PPadAddrWd-1:0] addr_q, addr_d;
  logic [PPadAddrWd-1:0] last_q, last_d;
  logic                  inflight_q;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr;
  logic [PsumDWd-1:0]    fifo_q [2];

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [OccWd-1:0]      occ;
  logic [SizeWd-1:0]     n_clamp;

  // Entry count clamped to the physical PPad depth
  always_comb begin
    n_clamp = ppad_size_i;
    if (ppad_size_i > SizeWd'(PPadSize)) begin
      n_clamp = SizeWd'(PPadSize);
    end
  end

  // Issue a read only if the data it returns is guaranteed a FIFO slot
  always_comb begin
    pop      = (count_q != 2'd0) && psum_ready_i;
    push     = inflight_q;
    occ      = OccWd'(count_q) + OccWd'(inflight_q) - OccWd'(pop);
    issue    = (state_q == StRead) && (occ < OccWd'(2));
    count_d  = 2'(OccWd'(count_q) + OccWd'(push) - OccWd'(pop));
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr   = rd_ptr_q ^ count_q[0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (drain_start_i) begin
          addr_d = '0;
          last_d = PPadAddrWd'(n_clamp - SizeWd'(1));
          if (n_clamp == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (issue) begin
          if (addr_q == last_q) begin
            state_d = StFlush;
          end else begin
            addr_d = addr_q + PPadAddrWd'(1);
          end
        end
      end
      StFlush: begin
        // Leave once the last entry's handshake empties the FIFO this cycle
        if (count_d == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      last_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      inflight_q <= issue;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        fifo_q[wr_ptr] <= ppad_rdata_i;
      end
    end
  end

  // Output decode; read strobe is combinational so the issue rule sees this cycle's pop
  always_comb begin
    ppad_read_o  = issue;
    ppad_raddr_o = (state_q == StRead) ? addr_q : '0;
    psum_valid_o = (count_q != 2'd0);
    psum_data_o  = psum_valid_o ? fifo_q[rd_ptr_q] : '0;
    busy_o       = (state_q == StRead) || (state_q == StFlush);
    done_o       = (state_q == StDone);
  end

endmodule
